// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_t;

    // Requester port ids
    localparam logic REQ_PIPE = 1'b0;  // core pipeline memory stage
    localparam logic REQ_XFER = 1'b1;  // weight/result transfer engine

    // Response payload returned for completed stores
    localparam logic [31:0] STORE_RSP_DATA = 32'h0000_0000;

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way grant selection for the data-memory arbiter.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie breaking;
// without it port 0 has fixed priority on a tie.
module dmem_arb_pick (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,  // port granted on the previous accept
    output logic [1:0] grant        // one-hot, bit N = port N
);

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority ignores history; keep the input tied off cleanly.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Grant the single requester, or break a tie by the configured policy
    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant = last_grant ? 2'b01 : 2'b10;
`else
            grant = 2'b01;
`endif
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter and access sequencer for the shared data memory.
// Port 0 = core pipeline, port 1 = transfer engine. Each accepted command
// occupies one ISSUE cycle on the memory port and yields one registered
// response pulse the following cycle.
// Build option: ARB_ROUND_ROBIN_EN (round-robin ties; default fixed priority).
module data_mem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int IN_BUS_WIDTH = 32,
    parameter int MEMORY_WIDTH = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    reqValid0,
    input  logic                    reqWrite0,
    input  logic [IN_BUS_WIDTH-1:0] reqAddr0,
    input  logic [MEMORY_WIDTH-1:0] reqData0,
    output logic                    reqReady0,
    input  logic                    reqValid1,
    input  logic                    reqWrite1,
    input  logic [IN_BUS_WIDTH-1:0] reqAddr1,
    input  logic [MEMORY_WIDTH-1:0] reqData1,
    output logic                    reqReady1,
    output logic                    rspValid0,
    output logic [MEMORY_WIDTH-1:0] rspData0,
    output logic                    rspValid1,
    output logic [MEMORY_WIDTH-1:0] rspData1,
    output logic                    memWriteEn,
    output logic                    memReadEn,
    output logic [IN_BUS_WIDTH-1:0] memAddr,
    output logic [MEMORY_WIDTH-1:0] memWriteData,
    input  logic [MEMORY_WIDTH-1:0] memReadData
);

    localparam logic [MEMORY_WIDTH-1:0] STORE_DATA = MEMORY_WIDTH'(STORE_RSP_DATA);

    arb_state_t              state_q, state_d;
    logic                    cmd_write_q, cmd_write_d;
    logic [IN_BUS_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [MEMORY_WIDTH-1:0] cmd_data_q, cmd_data_d;
    logic                    cmd_port_q, cmd_port_d;
    logic [1:0]              rsp_valid_q, rsp_valid_d;
    logic [MEMORY_WIDTH-1:0] rsp_data0_q, rsp_data0_d;
    logic [MEMORY_WIDTH-1:0] rsp_data1_q, rsp_data1_d;
    logic [1:0]              grant;
    logic                    last_grant;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;
    assign last_grant = last_grant_q;

    // Remember which port won the most recent accept
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) last_grant_q <= REQ_XFER;  // port 0 wins the first tie
        else     last_grant_q <= last_grant_d;
    end

    assign last_grant_d = (state_q == ARB_IDLE && grant != 2'b00) ? grant[1] : last_grant_q;
`else
    assign last_grant = REQ_XFER;
`endif

    dmem_arb_pick u_pick (
        .valid0     (reqValid0),
        .valid1     (reqValid1),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // State, captured command and response registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ARB_IDLE;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            cmd_port_q  <= REQ_PIPE;
            rsp_valid_q <= 2'b00;
            rsp_data0_q <= '0;
            rsp_data1_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            cmd_port_q  <= cmd_port_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data0_q <= rsp_data0_d;
            rsp_data1_q <= rsp_data1_d;
        end
    end

    // Next-state, command capture, accept strobes and response generation
    always_comb begin
        state_d     = state_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        cmd_port_d  = cmd_port_q;
        rsp_valid_d = 2'b00;
        rsp_data0_d = rsp_data0_q;
        rsp_data1_d = rsp_data1_q;
        reqReady0   = 1'b0;
        reqReady1   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                reqReady0 = grant[0] & reqValid0;
                reqReady1 = grant[1] & reqValid1;
                if (grant != 2'b00) begin
                    state_d = ARB_ISSUE;
                    if (grant[1]) begin
                        cmd_write_d = reqWrite1;
                        cmd_addr_d  = reqAddr1;
                        cmd_data_d  = reqData1;
                        cmd_port_d  = REQ_XFER;
                    end else begin
                        cmd_write_d = reqWrite0;
                        cmd_addr_d  = reqAddr0;
                        cmd_data_d  = reqData0;
                        cmd_port_d  = REQ_PIPE;
                    end
                end
            end
            ARB_ISSUE: begin
                state_d                 = ARB_IDLE;
                rsp_valid_d[cmd_port_q] = 1'b1;
                if (cmd_port_q == REQ_XFER)
                    rsp_data1_d = cmd_write_q ? STORE_DATA : memReadData;
                else
                    rsp_data0_d = cmd_write_q ? STORE_DATA : memReadData;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Memory port: enables only during ISSUE, address/data hold the last command
    assign memWriteEn   = (state_q == ARB_ISSUE) &  cmd_write_q;
    assign memReadEn    = (state_q == ARB_ISSUE) & ~cmd_write_q;
    assign memAddr      = cmd_addr_q;
    assign memWriteData = cmd_data_q;

    assign rspValid0 = rsp_valid_q[0];
    assign rspValid1 = rsp_valid_q[1];
    assign rspData0  = rsp_data0_q;
    assign rspData1  = rsp_data1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a response scoreboard and a
// small behavioural memory.
module tb_data_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        reqValid0 = 1'b0, reqWrite0 = 1'b0;
    logic [31:0] reqAddr0 = '0, reqData0 = '0;
    logic        reqValid1 = 1'b0, reqWrite1 = 1'b0;
    logic [31:0] reqAddr1 = '0, reqData1 = '0;
    logic        reqReady0, reqReady1;
    logic        rspValid0, rspValid1;
    logic [31:0] rspData0, rspData1;
    logic        memWriteEn, memReadEn;
    logic [31:0] memAddr, memWriteData, memReadData;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } rsp_t;
    rsp_t exp_q[$];

    logic [31:0] mem_model [16];

    data_mem_arbiter #(.IN_BUS_WIDTH(32), .MEMORY_WIDTH(32)) dut (
        .CLK(CLK), .RST(RST),
        .reqValid0(reqValid0), .reqWrite0(reqWrite0), .reqAddr0(reqAddr0), .reqData0(reqData0),
        .reqReady0(reqReady0),
        .reqValid1(reqValid1), .reqWrite1(reqWrite1), .reqAddr1(reqAddr1), .reqData1(reqData1),
        .reqReady1(reqReady1),
        .rspValid0(rspValid0), .rspData0(rspData0),
        .rspValid1(rspValid1), .rspData1(rspData1),
        .memWriteEn(memWriteEn), .memReadEn(memReadEn), .memAddr(memAddr),
        .memWriteData(memWriteData), .memReadData(memReadData)
    );

    always #5 CLK = ~CLK;

    // Behavioural memory: combinational read, write on the clock edge
    assign memReadData = memReadEn ? mem_model[memAddr[3:0]] : 32'h0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) mem_model[i] <= 32'h100 + i;
            mem_model[0] <= 32'h11;
            mem_model[1] <= 32'h22;
            mem_model[3] <= 32'hAB;
        end else if (memWriteEn) begin
            mem_model[memAddr[3:0]] <= memWriteData;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    endtask

    task automatic mon(input logic p, input logic v, input logic [31:0] d);
        rsp_t e;
        if (!v) return;
        if (exp_q.size() == 0) begin
            n_total++;
            $error("FAIL rsp_unexpected: port %0d data 0x%08h, required no response", p, d);
        end else begin
            e = exp_q.pop_front();
            check("rsp_port", {31'b0, p}, {31'b0, e.port});
            check("rsp_data", d, e.data);
        end
    endtask

    // Scoreboard monitor and enable exclusivity, sampled mid-cycle
    always @(negedge CLK) begin
        if (!RST) begin
            mon(1'b0, rspValid0, rspData0);
            mon(1'b1, rspValid1, rspData1);
            check("en_exclusive", {31'b0, memWriteEn & memReadEn}, 32'h0);
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic p, input logic [31:0] d);
        rsp_t e;
        e.port = p;
        e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic g;
        // ---- reset state
        #1 RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_rspValid0", {31'b0, rspValid0}, 0);
        check("rst_rspValid1", {31'b0, rspValid1}, 0);
        check("rst_rspData0", rspData0, 0);
        check("rst_rspData1", rspData1, 0);
        check("rst_wen", {31'b0, memWriteEn}, 0);
        check("rst_ren", {31'b0, memReadEn}, 0);
        check("rst_addr", memAddr, 0);
        check("rst_wdata", memWriteData, 0);
        RST = 1'b0;
        tick();

        // ---- single load, port 0, addr 3
        reqValid0 = 1; reqWrite0 = 0; reqAddr0 = 3;
        #1;
        check("ld_ready0", {31'b0, reqReady0}, 1);
        check("ld_ready1", {31'b0, reqReady1}, 0);
        push(1'b0, 32'hAB);
        tick();
        reqValid0 = 0;
        check("ld_ren", {31'b0, memReadEn}, 1);
        check("ld_wen", {31'b0, memWriteEn}, 0);
        check("ld_addr", memAddr, 3);
        tick();
        check("ld_rspValid0", {31'b0, rspValid0}, 1);
        check("ld_rspData0", rspData0, 32'hAB);
        check("ld_rspValid1", {31'b0, rspValid1}, 0);
        check("ld_rspData1", rspData1, 0);
        check("ld_ren_off", {31'b0, memReadEn}, 0);

        // ---- single store, port 1, addr 7
        reqValid1 = 1; reqWrite1 = 1; reqAddr1 = 7; reqData1 = 32'h1234;
        #1;
        check("st_ready1", {31'b0, reqReady1}, 1);
        push(1'b1, 32'h0);
        tick();
        reqValid1 = 0;
        check("st_wen", {31'b0, memWriteEn}, 1);
        check("st_ren", {31'b0, memReadEn}, 0);
        check("st_addr", memAddr, 7);
        check("st_wdata", memWriteData, 32'h1234);
        tick();
        check("st_rspValid1", {31'b0, rspValid1}, 1);
        check("st_rspData1", rspData1, 0);
        check("st_rspValid0", {31'b0, rspValid0}, 0);
        check("st_rspData0_held", rspData0, 32'hAB);
        check("st_ren_after", {31'b0, memReadEn}, 0);
        check("st_mem7", mem_model[7], 32'h1234);

        // ---- both ports valid for 8 cycles
        reqValid0 = 1; reqWrite0 = 0; reqAddr0 = 0;
        reqValid1 = 1; reqWrite1 = 0; reqAddr1 = 1;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            g = (i % 2) == 1;
`else
            g = 1'b0;
`endif
            #1;
            check("tie_ready0", {31'b0, reqReady0}, {31'b0, ~g});
            check("tie_ready1", {31'b0, reqReady1}, {31'b0, g});
            push(g, g ? 32'h22 : 32'h11);
            tick();
            check("tie_issue_ready", {30'b0, reqReady1, reqReady0}, 0);
            check("tie_addr", memAddr, {31'b0, g});
            tick();
        end
        reqValid0 = 0; reqValid1 = 0;
        tick();

        // ---- port 1 drops valid before acceptance
        reqValid0 = 1; reqWrite0 = 0; reqAddr0 = 3;
        reqValid1 = 1; reqWrite1 = 1; reqAddr1 = 9; reqData1 = 32'h55;
        #1;
        check("drop_ready0", {31'b0, reqReady0}, 1);
        check("drop_ready1", {31'b0, reqReady1}, 0);
        push(1'b0, 32'hAB);
        tick();
        reqValid0 = 0; reqValid1 = 0;
        check("drop_addr", memAddr, 3);
        check("drop_ren", {31'b0, memReadEn}, 1);
        tick();
        check("drop_ready1_after", {31'b0, reqReady1}, 0);
        tick();
        check("drop_wen", {31'b0, memWriteEn}, 0);
        check("drop_ren_idle", {31'b0, memReadEn}, 0);
        tick();
        check("drop_mem9", mem_model[9], 32'h109);

        // ---- reset in the middle of ISSUE
        reqValid0 = 1; reqWrite0 = 1; reqAddr0 = 5; reqData0 = 32'h77;
        tick();
        reqValid0 = 0;
        check("rstmid_wen_before", {31'b0, memWriteEn}, 1);
        RST = 1'b1;
        #1;
        check("rstmid_wen", {31'b0, memWriteEn}, 0);
        check("rstmid_ren", {31'b0, memReadEn}, 0);
        tick();
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rstmid_no_rsp", {30'b0, rspValid1, rspValid0}, 0);
        end
        reqValid0 = 1; reqWrite0 = 0; reqAddr0 = 0;
        reqValid1 = 1; reqWrite1 = 0; reqAddr1 = 1;
        #1;
        check("rst_tie_ready0", {31'b0, reqReady0}, 1);
        check("rst_tie_ready1", {31'b0, reqReady1}, 0);
        push(1'b0, 32'h11);
        tick();
        reqValid0 = 0; reqValid1 = 0;
        tick();
        tick();

        // ---- back-to-back loads from port 0
        reqValid0 = 1; reqWrite0 = 0; reqAddr0 = 0;
        #1;
        check("b2b_ready_a", {31'b0, reqReady0}, 1);
        push(1'b0, 32'h11);
        tick();
        reqAddr0 = 1;
        check("b2b_addr_a", memAddr, 0);
        check("b2b_ready_issue", {31'b0, reqReady0}, 0);
        tick();
        check("b2b_ready_b", {31'b0, reqReady0}, 1);
        check("b2b_rsp_a_valid", {31'b0, rspValid0}, 1);
        check("b2b_rsp_a_data", rspData0, 32'h11);
        push(1'b0, 32'h22);
        tick();
        reqValid0 = 0;
        check("b2b_addr_b", memAddr, 1);
        check("b2b_ren_b", {31'b0, memReadEn}, 1);
        tick();
        check("b2b_rsp_b_valid", {31'b0, rspValid0}, 1);
        check("b2b_rsp_b_data", rspData0, 32'h22);
        tick();
        tick();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
